// File: rtl/uart_pkg.sv
// Shared UART TAP definitions: IR addresses, DTMCS reset bits, write-path FSM states
// and the address-to-target decode used by tap_write_interconnect.
package uart_pkg;

    localparam int unsigned IRLENGTH = 5;

    localparam logic [IRLENGTH-1:0] ADDR_NOP      = 5'h00;
    localparam logic [IRLENGTH-1:0] ADDR_IDCODE   = 5'h01;
    localparam logic [IRLENGTH-1:0] ADDR_STB0_CS  = 5'h04;
    localparam logic [IRLENGTH-1:0] ADDR_STB0_D   = 5'h05;
    localparam logic [IRLENGTH-1:0] ADDR_STB1_CS  = 5'h06;
    localparam logic [IRLENGTH-1:0] ADDR_STB1_D   = 5'h07;
    localparam logic [IRLENGTH-1:0] ADDR_DTMCS    = 5'h10;
    localparam logic [IRLENGTH-1:0] ADDR_DMI      = 5'h11;
    localparam logic [IRLENGTH-1:0] ADDR_IDLECODE = 5'h1f;

    localparam int unsigned DTMCS_DMIRESET_BIT     = 16;
    localparam int unsigned DTMCS_DMIHARDRESET_BIT = 17;

    // One-hot target vector bit positions
    localparam int unsigned NUM_TARGETS  = 5;
    localparam int unsigned TGT_DMI      = 0;
    localparam int unsigned TGT_STB0_CS  = 1;
    localparam int unsigned TGT_STB0_D   = 2;
    localparam int unsigned TGT_STB1_CS  = 3;
    localparam int unsigned TGT_STB1_D   = 4;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_SEND,
        WR_DROP
    } wr_state_e;

    // Returns the one-hot device target for an address; zero means "not a device".
    function automatic logic [NUM_TARGETS-1:0] decode_target(input logic [IRLENGTH-1:0] addr);
        case (addr)
            ADDR_DMI:     return 5'b00001;
            ADDR_STB0_CS: return 5'b00010;
            ADDR_STB0_D:  return 5'b00100;
            ADDR_STB1_CS: return 5'b01000;
            ADDR_STB1_D:  return 5'b10000;
            default:      return '0;
        endcase
    endfunction

endpackage

// File: rtl/tap_write_interconnect_timeout.sv
// Stall counter for the SEND state; instantiated only when TAP_WRITE_TIMEOUT_EN is defined.
module tap_write_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // Fires on the TIMEOUT_CYCLES-th stalled cycle so the valid is high exactly that long.
    assign expired = count_en && (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (expired) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/tap_write_interconnect.sv
// Registered one-outstanding write demux from the TAP write arbiter to DMI/STB devices,
// with DTMCS writes decoded into reset pulses. Optional stall timeout: TAP_WRITE_TIMEOUT_EN.
module tap_write_interconnect
    import uart_pkg::*;
#(
    parameter int unsigned WRITE_WIDTH      = 41,
    parameter int unsigned DMI_WIDTH        = 41,
    parameter int unsigned STB_STATUS_WIDTH = 8,
    parameter int unsigned STB_DATA_WIDTH   = 32,
    parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
    input  logic                        CLK_I,
    input  logic                        RST_NI,
    input  logic [IRLENGTH-1:0]         WRITE_ADDRESS_I,
    input  logic [WRITE_WIDTH-1:0]      WRITE_DATA_I,
    input  logic                        WRITE_VALID_I,
    output logic                        WRITE_READY_O,
    output logic                        WRITE_ERROR_O,
    output logic [DMI_WIDTH-1:0]        DMI_WRITE_DATA_O,
    output logic                        DMI_WRITE_VALID_O,
    input  logic                        DMI_WRITE_READY_I,
    output logic                        DMI_RESET_O,
    output logic                        DMI_HARD_RESET_O,
    output logic [STB_STATUS_WIDTH-1:0] STB0_CONTROL_O,
    output logic                        STB0_CONTROL_VALID_O,
    input  logic                        STB0_CONTROL_READY_I,
    output logic [STB_DATA_WIDTH-1:0]   STB0_DATA_O,
    output logic                        STB0_DATA_VALID_O,
    input  logic                        STB0_DATA_READY_I,
    output logic [STB_STATUS_WIDTH-1:0] STB1_CONTROL_O,
    output logic                        STB1_CONTROL_VALID_O,
    input  logic                        STB1_CONTROL_READY_I,
    output logic [STB_DATA_WIDTH-1:0]   STB1_DATA_O,
    output logic                        STB1_DATA_VALID_O,
    input  logic                        STB1_DATA_READY_I
);

    wr_state_e              state, state_next;
    logic                   ready_q, ready_next;
    logic                   error_q, error_next;
    logic                   dmi_reset_q, dmi_reset_next;
    logic                   dmi_hard_reset_q, dmi_hard_reset_next;
    logic [NUM_TARGETS-1:0] valid_q, valid_next;
    logic [NUM_TARGETS-1:0] load;
    logic [NUM_TARGETS-1:0] hit;
    logic [NUM_TARGETS-1:0] device_ready;
    logic                   accept;
    logic                   sel_ready;
    logic                   timeout_hit;

    logic [DMI_WIDTH-1:0]        dmi_data_q;
    logic [STB_STATUS_WIDTH-1:0] stb0_ctrl_q, stb1_ctrl_q;
    logic [STB_DATA_WIDTH-1:0]   stb0_data_q, stb1_data_q;

    assign hit    = decode_target(WRITE_ADDRESS_I);
    assign accept = WRITE_VALID_I && ready_q;

    assign device_ready = {STB1_DATA_READY_I, STB1_CONTROL_READY_I, STB0_DATA_READY_I,
                           STB0_CONTROL_READY_I, DMI_WRITE_READY_I};
    // valid_q is one-hot in SEND, so masking selects only the addressed device's ready.
    assign sel_ready = |(device_ready & valid_q);

`ifdef TAP_WRITE_TIMEOUT_EN
    logic count_en;
    assign count_en = (state == WR_SEND) && !sel_ready;

    tap_write_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (CLK_I),
        .rst_n   (RST_NI),
        .clear   (accept),
        .count_en(count_en),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next          = state;
        ready_next          = ready_q;
        valid_next          = valid_q;
        error_next          = 1'b0;
        dmi_reset_next      = 1'b0;
        dmi_hard_reset_next = 1'b0;
        load                = '0;
        case (state)
            WR_IDLE: begin
                ready_next = 1'b1;
                if (accept) begin
                    ready_next = 1'b0;
                    load       = hit;
                    if (hit != '0) begin
                        state_next = WR_SEND;
                        valid_next = hit;
                    end else begin
                        state_next = WR_DROP;
                        if (WRITE_ADDRESS_I == ADDR_DTMCS) begin
                            dmi_reset_next      = WRITE_DATA_I[DTMCS_DMIRESET_BIT];
                            dmi_hard_reset_next = WRITE_DATA_I[DTMCS_DMIHARDRESET_BIT];
                        end
                    end
                end
            end
            WR_SEND: begin
                if (sel_ready || timeout_hit) begin
                    state_next = WR_IDLE;
                    valid_next = '0;
                    ready_next = 1'b1;
                    error_next = !sel_ready;
                end
            end
            WR_DROP: begin
                state_next = WR_IDLE;
                ready_next = 1'b1;
            end
            default: begin
                state_next = WR_IDLE;
                valid_next = '0;
                ready_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (!RST_NI) begin
            state            <= WR_IDLE;
            ready_q          <= 1'b0;
            error_q          <= 1'b0;
            dmi_reset_q      <= 1'b0;
            dmi_hard_reset_q <= 1'b0;
            valid_q          <= '0;
            dmi_data_q       <= '0;
            stb0_ctrl_q      <= '0;
            stb0_data_q      <= '0;
            stb1_ctrl_q      <= '0;
            stb1_data_q      <= '0;
        end else begin
            state            <= state_next;
            ready_q          <= ready_next;
            error_q          <= error_next;
            dmi_reset_q      <= dmi_reset_next;
            dmi_hard_reset_q <= dmi_hard_reset_next;
            valid_q          <= valid_next;
            if (load[TGT_DMI])     dmi_data_q  <= WRITE_DATA_I[DMI_WIDTH-1:0];
            if (load[TGT_STB0_CS]) stb0_ctrl_q <= WRITE_DATA_I[STB_STATUS_WIDTH-1:0];
            if (load[TGT_STB0_D])  stb0_data_q <= WRITE_DATA_I[STB_DATA_WIDTH-1:0];
            if (load[TGT_STB1_CS]) stb1_ctrl_q <= WRITE_DATA_I[STB_STATUS_WIDTH-1:0];
            if (load[TGT_STB1_D])  stb1_data_q <= WRITE_DATA_I[STB_DATA_WIDTH-1:0];
        end
    end

    assign WRITE_READY_O        = ready_q;
    assign WRITE_ERROR_O        = error_q;
    assign DMI_RESET_O          = dmi_reset_q;
    assign DMI_HARD_RESET_O     = dmi_hard_reset_q;
    assign DMI_WRITE_DATA_O     = dmi_data_q;
    assign DMI_WRITE_VALID_O    = valid_q[TGT_DMI];
    assign STB0_CONTROL_O       = stb0_ctrl_q;
    assign STB0_CONTROL_VALID_O = valid_q[TGT_STB0_CS];
    assign STB0_DATA_O          = stb0_data_q;
    assign STB0_DATA_VALID_O    = valid_q[TGT_STB0_D];
    assign STB1_CONTROL_O       = stb1_ctrl_q;
    assign STB1_CONTROL_VALID_O = valid_q[TGT_STB1_CS];
    assign STB1_DATA_O          = stb1_data_q;
    assign STB1_DATA_VALID_O    = valid_q[TGT_STB1_D];

endmodule
